// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures decoded operands and control from ID and
// presents them to EX for one cycle, with stall (hold) and flush (bubble).
module id_ex_pipeline_register (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        in_Valid,
  input  logic [31:0] in_PC_4,
  input  logic [31:0] in_ReadData1,
  input  logic [31:0] in_ReadData2,
  input  logic [31:0] in_ShamtExtend,
  input  logic [31:0] in_InmmediateExtend,
  input  logic [25:0] in_JumpNoShifted,
  input  logic [2:0]  in_ALUOp,
  input  logic [5:0]  in_ALUFunction,
  input  logic        in_ShamtSelector,
  input  logic        in_ALUSrc,
  input  logic [4:0]  in_Rs,
  input  logic [4:0]  in_Rt,
  input  logic [4:0]  in_WriteRegister,
  input  logic        in_RegWrite,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_MemtoReg,
  input  logic        in_BranchEQ,
  input  logic        in_BranchNE,
  input  logic        in_Jump,
  output logic        out_Valid,
  output logic [31:0] out_PC_4,
  output logic [31:0] out_ReadData1,
  output logic [31:0] out_ReadData2,
  output logic [31:0] out_ShamtExtend,
  output logic [31:0] out_InmmediateExtend,
  output logic [25:0] out_JumpNoShifted,
  output logic [2:0]  out_ALUOp,
  output logic [5:0]  out_ALUFunction,
  output logic        out_ShamtSelector,
  output logic        out_ALUSrc,
  output logic [4:0]  out_Rs,
  output logic [4:0]  out_Rt,
  output logic [4:0]  out_WriteRegister,
  output logic        out_RegWrite,
  output logic        out_MemRead,
  output logic        out_MemWrite,
  output logic        out_MemtoReg,
  output logic        out_BranchEQ,
  output logic        out_BranchNE,
  output logic        out_Jump
);

  // Fixed at 32: jump target formation downstream relies on PC[31:28].
  localparam int unsigned NBits   = 32;
  localparam int unsigned JumpW   = 26;
  localparam int unsigned AluOpW  = 3;
  localparam int unsigned AluFnW  = 6;
  localparam int unsigned RegW    = 5;

  typedef struct packed {
    logic [NBits-1:0]  pc_4;
    logic [NBits-1:0]  read_data1;
    logic [NBits-1:0]  read_data2;
    logic [NBits-1:0]  shamt_extend;
    logic [NBits-1:0]  imm_extend;
    logic [JumpW-1:0]  jump_no_shifted;
    logic [AluOpW-1:0] alu_op;
    logic [AluFnW-1:0] alu_function;
    logic              shamt_selector;
    logic              alu_src;
    logic [RegW-1:0]   rs;
    logic [RegW-1:0]   rt;
    logic [RegW-1:0]   write_register;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch_eq;
    logic              branch_ne;
    logic              jump;
    logic              valid;
  } id_ex_t;

  id_ex_t stage_d, stage_q;

  // Next contents: flush inserts a bubble, stall holds, otherwise load from ID.
  always_comb begin
    stage_d = stage_q;
    if (Flush) begin
      stage_d = '0;
    end else if (!Stall) begin
      stage_d.pc_4            = in_PC_4;
      stage_d.read_data1      = in_ReadData1;
      stage_d.read_data2      = in_ReadData2;
      stage_d.shamt_extend    = in_ShamtExtend;
      stage_d.imm_extend      = in_InmmediateExtend;
      stage_d.jump_no_shifted = in_JumpNoShifted;
      stage_d.alu_op          = in_ALUOp;
      stage_d.alu_function    = in_ALUFunction;
      stage_d.shamt_selector  = in_ShamtSelector;
      stage_d.alu_src         = in_ALUSrc;
      stage_d.rs              = in_Rs;
      stage_d.rt              = in_Rt;
      stage_d.write_register  = in_WriteRegister;
      stage_d.mem_to_reg      = in_MemtoReg;
      stage_d.valid           = in_Valid;
      // An invalid slot must not touch architectural state or redirect fetch.
      stage_d.reg_write       = in_RegWrite  & in_Valid;
      stage_d.mem_read        = in_MemRead   & in_Valid;
      stage_d.mem_write       = in_MemWrite  & in_Valid;
      stage_d.branch_eq       = in_BranchEQ  & in_Valid;
      stage_d.branch_ne       = in_BranchNE  & in_Valid;
      stage_d.jump            = in_Jump      & in_Valid;
    end
  end

  // Stage register; synchronous reset overrides stall and flush.
  always_ff @(posedge clk) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign out_Valid            = stage_q.valid;
  assign out_PC_4             = stage_q.pc_4;
  assign out_ReadData1        = stage_q.read_data1;
  assign out_ReadData2        = stage_q.read_data2;
  assign out_ShamtExtend      = stage_q.shamt_extend;
  assign out_InmmediateExtend = stage_q.imm_extend;
  assign out_JumpNoShifted    = stage_q.jump_no_shifted;
  assign out_ALUOp            = stage_q.alu_op;
  assign out_ALUFunction      = stage_q.alu_function;
  assign out_ShamtSelector    = stage_q.shamt_selector;
  assign out_ALUSrc           = stage_q.alu_src;
  assign out_Rs               = stage_q.rs;
  assign out_Rt               = stage_q.rt;
  assign out_WriteRegister    = stage_q.write_register;
  assign out_RegWrite         = stage_q.reg_write;
  assign out_MemRead          = stage_q.mem_read;
  assign out_MemWrite         = stage_q.mem_write;
  assign out_MemtoReg         = stage_q.mem_to_reg;
  assign out_BranchEQ         = stage_q.branch_eq;
  assign out_BranchNE         = stage_q.branch_ne;
  assign out_Jump             = stage_q.jump;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Table-driven bench for the ID/EX pipeline register.
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic [31:0] pc_4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] shamt;
    logic [31:0] imm;
    logic [25:0] jns;
    logic [2:0]  alu_op;
    logic [5:0]  alu_fn;
    logic        shamt_sel;
    logic        alu_src;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        beq;
    logic        bne;
    logic        jump;
    logic        valid;
  } fields_t;

  typedef struct {
    logic    stall;
    logic    flush;
    fields_t in;
    fields_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset, Stall, Flush, in_Valid;
  logic [31:0] in_PC_4, in_ReadData1, in_ReadData2, in_ShamtExtend, in_InmmediateExtend;
  logic [25:0] in_JumpNoShifted;
  logic [2:0]  in_ALUOp;
  logic [5:0]  in_ALUFunction;
  logic        in_ShamtSelector, in_ALUSrc;
  logic [4:0]  in_Rs, in_Rt, in_WriteRegister;
  logic        in_RegWrite, in_MemRead, in_MemWrite, in_MemtoReg, in_BranchEQ, in_BranchNE, in_Jump;
  logic        out_Valid;
  logic [31:0] out_PC_4, out_ReadData1, out_ReadData2, out_ShamtExtend, out_InmmediateExtend;
  logic [25:0] out_JumpNoShifted;
  logic [2:0]  out_ALUOp;
  logic [5:0]  out_ALUFunction;
  logic        out_ShamtSelector, out_ALUSrc;
  logic [4:0]  out_Rs, out_Rt, out_WriteRegister;
  logic        out_RegWrite, out_MemRead, out_MemWrite, out_MemtoReg, out_BranchEQ, out_BranchNE, out_Jump;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_register dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .in_Valid(in_Valid),
    .in_PC_4(in_PC_4), .in_ReadData1(in_ReadData1), .in_ReadData2(in_ReadData2),
    .in_ShamtExtend(in_ShamtExtend), .in_InmmediateExtend(in_InmmediateExtend),
    .in_JumpNoShifted(in_JumpNoShifted), .in_ALUOp(in_ALUOp), .in_ALUFunction(in_ALUFunction),
    .in_ShamtSelector(in_ShamtSelector), .in_ALUSrc(in_ALUSrc), .in_Rs(in_Rs), .in_Rt(in_Rt),
    .in_WriteRegister(in_WriteRegister), .in_RegWrite(in_RegWrite), .in_MemRead(in_MemRead),
    .in_MemWrite(in_MemWrite), .in_MemtoReg(in_MemtoReg), .in_BranchEQ(in_BranchEQ),
    .in_BranchNE(in_BranchNE), .in_Jump(in_Jump),
    .out_Valid(out_Valid), .out_PC_4(out_PC_4), .out_ReadData1(out_ReadData1),
    .out_ReadData2(out_ReadData2), .out_ShamtExtend(out_ShamtExtend),
    .out_InmmediateExtend(out_InmmediateExtend), .out_JumpNoShifted(out_JumpNoShifted),
    .out_ALUOp(out_ALUOp), .out_ALUFunction(out_ALUFunction),
    .out_ShamtSelector(out_ShamtSelector), .out_ALUSrc(out_ALUSrc), .out_Rs(out_Rs),
    .out_Rt(out_Rt), .out_WriteRegister(out_WriteRegister), .out_RegWrite(out_RegWrite),
    .out_MemRead(out_MemRead), .out_MemWrite(out_MemWrite), .out_MemtoReg(out_MemtoReg),
    .out_BranchEQ(out_BranchEQ), .out_BranchNE(out_BranchNE), .out_Jump(out_Jump)
  );

  // Build a record whose secondary fields are derived from pc4 so each row differs everywhere.
  function automatic fields_t mk(logic [31:0] pc4, logic [5:0] fn, logic [6:0] ctrl,
                                 logic [4:0] wr, logic [31:0] imm, logic valid);
    fields_t f;
    f.pc_4      = pc4;
    f.rd1       = pc4 ^ 32'hA5A5_0F0F;
    f.rd2       = ~pc4;
    f.shamt     = {27'd0, pc4[4:0]};
    f.imm       = imm;
    f.jns       = 26'(pc4 * 3);
    f.alu_op    = 3'(pc4 >> 2);
    f.alu_fn    = fn;
    f.shamt_sel = pc4[2];
    f.alu_src   = pc4[3];
    f.rs        = 5'(pc4 >> 2);
    f.rt        = 5'(pc4 >> 3);
    f.wr        = wr;
    {f.rw, f.mr, f.mw, f.m2r, f.beq, f.bne, f.jump} = ctrl;
    f.valid     = valid;
    return f;
  endfunction

  task automatic drive(fields_t f);
    in_PC_4 = f.pc_4; in_ReadData1 = f.rd1; in_ReadData2 = f.rd2;
    in_ShamtExtend = f.shamt; in_InmmediateExtend = f.imm; in_JumpNoShifted = f.jns;
    in_ALUOp = f.alu_op; in_ALUFunction = f.alu_fn; in_ShamtSelector = f.shamt_sel;
    in_ALUSrc = f.alu_src; in_Rs = f.rs; in_Rt = f.rt; in_WriteRegister = f.wr;
    in_RegWrite = f.rw; in_MemRead = f.mr; in_MemWrite = f.mw; in_MemtoReg = f.m2r;
    in_BranchEQ = f.beq; in_BranchNE = f.bne; in_Jump = f.jump; in_Valid = f.valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, fields_t e);
    chk({tag, ".pc_4"},   out_PC_4,                   e.pc_4);
    chk({tag, ".rd1"},    out_ReadData1,              e.rd1);
    chk({tag, ".rd2"},    out_ReadData2,              e.rd2);
    chk({tag, ".shamt"},  out_ShamtExtend,            e.shamt);
    chk({tag, ".imm"},    out_InmmediateExtend,       e.imm);
    chk({tag, ".jns"},    32'(out_JumpNoShifted),     32'(e.jns));
    chk({tag, ".aluop"},  32'(out_ALUOp),             32'(e.alu_op));
    chk({tag, ".alufn"},  32'(out_ALUFunction),       32'(e.alu_fn));
    chk({tag, ".shsel"},  32'(out_ShamtSelector),     32'(e.shamt_sel));
    chk({tag, ".alusrc"}, 32'(out_ALUSrc),            32'(e.alu_src));
    chk({tag, ".rs"},     32'(out_Rs),                32'(e.rs));
    chk({tag, ".rt"},     32'(out_Rt),                32'(e.rt));
    chk({tag, ".wr"},     32'(out_WriteRegister),     32'(e.wr));
    chk({tag, ".rw"},     32'(out_RegWrite),          32'(e.rw));
    chk({tag, ".mr"},     32'(out_MemRead),           32'(e.mr));
    chk({tag, ".mw"},     32'(out_MemWrite),          32'(e.mw));
    chk({tag, ".m2r"},    32'(out_MemtoReg),          32'(e.m2r));
    chk({tag, ".beq"},    32'(out_BranchEQ),          32'(e.beq));
    chk({tag, ".bne"},    32'(out_BranchNE),          32'(e.bne));
    chk({tag, ".jump"},   32'(out_Jump),              32'(e.jump));
    chk({tag, ".valid"},  32'(out_Valid),             32'(e.valid));
  endtask

  vec_t vecs[16];

  initial begin
    fields_t f, e, zero;
    zero = '0;

    // Rows are applied back to back, so stall rows expect the last loaded row.
    vecs[0]  = '{1'b0, 1'b0, mk(32'd4,  6'h20, 7'b1000000, 5'd3, 32'h0, 1'b1), mk(32'd4,  6'h20, 7'b1000000, 5'd3, 32'h0, 1'b1)};
    vecs[1]  = '{1'b0, 1'b0, mk(32'd8,  6'h21, 7'b0110000, 5'd4, 32'h1, 1'b1), mk(32'd8,  6'h21, 7'b0110000, 5'd4, 32'h1, 1'b1)};
    vecs[2]  = '{1'b0, 1'b0, mk(32'd12, 6'h22, 7'b0001101, 5'd5, 32'h2, 1'b1), mk(32'd12, 6'h22, 7'b0001101, 5'd5, 32'h2, 1'b1)};
    vecs[3]  = '{1'b0, 1'b0, mk(32'd16, 6'h23, 7'b1000010, 5'd6, 32'h10, 1'b1), mk(32'd16, 6'h23, 7'b1000010, 5'd6, 32'h10, 1'b1)};
    vecs[4]  = '{1'b1, 1'b0, mk(32'd20, 6'h24, 7'b0100000, 5'd7, 32'h3, 1'b1), mk(32'd16, 6'h23, 7'b1000010, 5'd6, 32'h10, 1'b1)};
    vecs[5]  = '{1'b1, 1'b0, mk(32'd20, 6'h24, 7'b0100000, 5'd7, 32'h3, 1'b0), mk(32'd16, 6'h23, 7'b1000010, 5'd6, 32'h10, 1'b1)};
    vecs[6]  = '{1'b0, 1'b0, mk(32'd20, 6'h24, 7'b0100000, 5'd7, 32'h3, 1'b1), mk(32'd20, 6'h24, 7'b0100000, 5'd7, 32'h3, 1'b1)};
    vecs[7]  = '{1'b0, 1'b1, mk(32'd24, 6'h25, 7'b0010000, 5'd9, 32'h4, 1'b1), zero};
    vecs[8]  = '{1'b1, 1'b1, mk(32'd24, 6'h25, 7'b0010000, 5'd9, 32'h4, 1'b1), zero};
    vecs[9]  = '{1'b0, 1'b0, mk(32'd28, 6'h26, 7'b1111111, 5'd10, 32'hFFFF_FFF0, 1'b0), mk(32'd28, 6'h26, 7'b0001000, 5'd10, 32'hFFFF_FFF0, 1'b0)};
    vecs[10] = '{1'b0, 1'b0, mk(32'd32, 6'h27, 7'b1111111, 5'd11, 32'h8000_0000, 1'b1), mk(32'd32, 6'h27, 7'b1111111, 5'd11, 32'h8000_0000, 1'b1)};
    vecs[11] = '{1'b0, 1'b0, mk(32'd36, 6'h20, 7'b1000000, 5'd12, 32'h5, 1'b1), mk(32'd36, 6'h20, 7'b1000000, 5'd12, 32'h5, 1'b1)};
    vecs[12] = '{1'b1, 1'b0, mk(32'd40, 6'h22, 7'b0000001, 5'd13, 32'h6, 1'b1), mk(32'd36, 6'h20, 7'b1000000, 5'd12, 32'h5, 1'b1)};
    vecs[13] = '{1'b1, 1'b0, mk(32'd40, 6'h22, 7'b0000001, 5'd13, 32'h6, 1'b1), mk(32'd36, 6'h20, 7'b1000000, 5'd12, 32'h5, 1'b1)};
    vecs[14] = '{1'b1, 1'b0, mk(32'd40, 6'h22, 7'b0000001, 5'd13, 32'h6, 1'b1), mk(32'd36, 6'h20, 7'b1000000, 5'd12, 32'h5, 1'b1)};
    vecs[15] = '{1'b0, 1'b0, mk(32'd40, 6'h22, 7'b0000001, 5'd13, 32'h6, 1'b1), mk(32'd40, 6'h22, 7'b0000001, 5'd13, 32'h6, 1'b1)};

    // Reset with all inputs high for two cycles.
    reset = 1'b1; Stall = 1'b1; Flush = 1'b0;
    drive('1);
    step();
    check_all("reset1", zero);
    step();
    check_all("reset2", zero);

    // First load after reset.
    reset = 1'b0; Stall = 1'b0;
    f = zero; f.rd1 = 32'h1234_5678; f.rw = 1'b1; f.valid = 1'b1;
    drive(f);
    step();
    check_all("post_reset", f);

    // Table: streaming, stall, flush, flush+stall, invalid slot.
    for (int i = 0; i < 16; i++) begin
      Stall = vecs[i].stall;
      Flush = vecs[i].flush;
      drive(vecs[i].in);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset during a stall clears everything despite Stall.
    Stall = 1'b0; Flush = 1'b0;
    f = mk(32'h0000_0100, 6'h2A, 7'b1010101, 5'd31, 32'h7FFF_FFFF, 1'b1);
    drive(f);
    step();
    check_all("pre_stall", f);
    Stall = 1'b1;
    drive(mk(32'h0000_0200, 6'h2B, 7'b0101010, 5'd1, 32'h1, 1'b1));
    step();
    check_all("stall_hold", f);
    reset = 1'b1;
    step();
    check_all("reset_in_stall", zero);

    // Reset also beats Flush; then the first clean edge loads normally.
    Flush = 1'b1; Stall = 1'b0;
    step();
    check_all("reset_flush", zero);
    reset = 1'b0; Flush = 1'b0;
    e = mk(32'hFFFF_FFFC, 6'h3F, 7'b1111111, 5'd17, 32'hDEAD_BEEF, 1'b1);
    drive(e);
    step();
    check_all("after_reset_load", e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
